nn_mac_lane_array: RTL and testbench

//   Parametrised multi-lane neuron core for the edge-AI accelerator: N_LANES

---
 rtl/nn_mac_lane_array.sv | 172 +++++++++++++++++
 tb/tb_nn_mac_lane_array.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/nn_mac_lane_array.sv
// Multi-lane neuron core: N_LANES MACs share one streamed input vector, each against its own
// weight row, then shift / optional ReLU / saturate and drain one lane result per handshake.
module nn_mac_lane_array #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned WGT_W   = 8,
    parameter int unsigned ACC_W   = 24,
    parameter int unsigned N_LANES = 4,
    parameter int unsigned VEC_LEN = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clr_i,
    input  logic                       cfg_relu_i,
    input  logic [3:0]                 cfg_shift_i,
    input  logic                       wgt_we_i,
    input  logic [$clog2(N_LANES)-1:0] wgt_lane_i,
    input  logic [$clog2(VEC_LEN)-1:0] wgt_addr_i,
    input  logic [WGT_W-1:0]           wgt_data_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [DATA_W-1:0]          in_data_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [DATA_W-1:0]          out_data_o,
    output logic [$clog2(N_LANES)-1:0] out_lane_o,
    output logic                       busy_o
);

    localparam int unsigned LANE_W = $clog2(N_LANES);
    localparam int unsigned CNT_W  = $clog2(VEC_LEN);
    localparam int unsigned PROD_W = DATA_W + WGT_W;

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        $signed({{(ACC_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}});
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        StAcc,
        StAct,
        StDrain
    } state_e;

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [LANE_W-1:0]         lane_q, lane_d;
    logic                      out_valid_q, out_valid_d;
    logic signed [WGT_W-1:0]   w_q   [N_LANES][VEC_LEN];
    logic signed [WGT_W-1:0]   w_d   [N_LANES][VEC_LEN];
    logic signed [ACC_W-1:0]   acc_q [N_LANES];
    logic signed [ACC_W-1:0]   acc_d [N_LANES];
    logic signed [DATA_W-1:0]  res_q [N_LANES];
    logic signed [DATA_W-1:0]  res_d [N_LANES];

    logic signed [PROD_W-1:0]  prod    [N_LANES];
    logic signed [ACC_W-1:0]   shifted [N_LANES];
    logic signed [DATA_W-1:0]  sat     [N_LANES];

    // Full-precision products; weights are read at the current sample index.
    always_comb begin
        for (int l = 0; l < N_LANES; l++) begin
            prod[l] = PROD_W'($signed(in_data_i)) * PROD_W'(w_q[l][cnt_q]);
        end
    end

    always_comb begin
        for (int l = 0; l < N_LANES; l++) begin
            shifted[l] = acc_q[l] >>> cfg_shift_i;
            if (cfg_relu_i && shifted[l][ACC_W-1]) begin
                shifted[l] = '0;
            end
            if (shifted[l] > SAT_MAX) begin
                sat[l] = SAT_MAX[DATA_W-1:0];
            end else if (shifted[l] < SAT_MIN) begin
                sat[l] = SAT_MIN[DATA_W-1:0];
            end else begin
                sat[l] = shifted[l][DATA_W-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lane_d      = lane_q;
        out_valid_d = out_valid_q;
        w_d         = w_q;
        acc_d       = acc_q;
        res_d       = res_q;

        // Weight port is independent of the FSM and of clr_i.
        if (wgt_we_i && (32'(wgt_lane_i) < N_LANES) && (32'(wgt_addr_i) < VEC_LEN)) begin
            w_d[wgt_lane_i][wgt_addr_i] = wgt_data_i;
        end

        if (clr_i) begin
            state_d     = StAcc;
            cnt_d       = '0;
            lane_d      = '0;
            out_valid_d = 1'b0;
            acc_d       = '{default: '0};
        end else begin
            case (state_q)
                StAcc: begin
                    if (in_valid_i) begin
                        for (int l = 0; l < N_LANES; l++) begin
                            acc_d[l] = acc_q[l] + ACC_W'(prod[l]);
                        end
                        if (cnt_q == CNT_W'(VEC_LEN - 1)) begin
                            cnt_d   = '0;
                            state_d = StAct;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                StAct: begin
                    res_d       = sat;
                    state_d     = StDrain;
                    out_valid_d = 1'b1;
                    lane_d      = '0;
                end
                StDrain: begin
                    if (out_ready_i) begin
                        if (lane_q == LANE_W'(N_LANES - 1)) begin
                            state_d     = StAcc;
                            out_valid_d = 1'b0;
                            lane_d      = '0;
                            cnt_d       = '0;
                            acc_d       = '{default: '0};
                        end else begin
                            lane_d = lane_q + LANE_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = StAcc;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StAcc;
            cnt_q       <= '0;
            lane_q      <= '0;
            out_valid_q <= 1'b0;
            for (int l = 0; l < N_LANES; l++) begin
                acc_q[l] <= '0;
                res_q[l] <= '0;
                for (int a = 0; a < VEC_LEN; a++) begin
                    w_q[l][a] <= '0;
                end
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lane_q      <= lane_d;
            out_valid_q <= out_valid_d;
            w_q         <= w_d;
            acc_q       <= acc_d;
            res_q       <= res_d;
        end
    end

    assign in_ready_o  = (state_q == StAcc);
    assign out_valid_o = out_valid_q;
    assign out_lane_o  = lane_q;
    assign out_data_o  = res_q[lane_q];
    assign busy_o      = (state_q != StAcc) || (cnt_q != '0);

endmodule

// File: tb/tb_nn_mac_lane_array.sv
// Bench for nn_mac_lane_array: table of vectors with per-lane expected results, checked by a
// drain-side scoreboard, plus latency, back-pressure, bubble, clear and reset sequences.
module tb_nn_mac_lane_array;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       cfg_relu = 1'b0;
    logic [3:0] cfg_shift = 4'd0;
    logic       wgt_we = 1'b0;
    logic [1:0] wgt_lane = 2'd0;
    logic [3:0] wgt_addr = 4'd0;
    logic [7:0] wgt_data = 8'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'd0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic [1:0] out_lane;
    logic       busy;

    nn_mac_lane_array dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .clr_i       (clr),
        .cfg_relu_i  (cfg_relu),
        .cfg_shift_i (cfg_shift),
        .wgt_we_i    (wgt_we),
        .wgt_lane_i  (wgt_lane),
        .wgt_addr_i  (wgt_addr),
        .wgt_data_i  (wgt_data),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_lane_o  (out_lane),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int w [4];
        int din;
        int sh;
        bit relu;
        bit load;
        bit gaps;
        bit bp;
        bit pre_clr;
        bit rst_mid;
        int res [4];
    } vec_t;

    typedef struct {
        int lane;
        int data;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input int act, input int want);
        n_tests++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, want);
        end
    endtask

    // Scoreboard: every result handshake pops one expected {lane, data}.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_lane", int'(out_lane), e.lane);
                chk("out_data", int'($signed(out_data)), e.data);
            end
        end
    end

    task automatic add_vec(input int w0, input int w1, input int w2, input int w3,
                           input int din, input int sh, input bit relu, input bit load,
                           input bit gaps, input bit bp, input bit pre_clr, input bit rst_mid,
                           input int r0, input int r1, input int r2, input int r3);
        vec_t v;
        v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
        v.din = din; v.sh = sh; v.relu = relu; v.load = load; v.gaps = gaps;
        v.bp = bp; v.pre_clr = pre_clr; v.rst_mid = rst_mid;
        v.res[0] = r0; v.res[1] = r1; v.res[2] = r2; v.res[3] = r3;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_weights(input vec_t v);
        for (int l = 0; l < 4; l++) begin
            for (int a = 0; a < 16; a++) begin
                wgt_we   = 1'b1;
                wgt_lane = 2'(l);
                wgt_addr = 4'(a);
                wgt_data = 8'(v.w[l]);
                tick();
            end
        end
        wgt_we = 1'b0;
    endtask

    task automatic beat(input int d);
        in_valid = 1'b1;
        in_data  = 8'(d);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int k;
        if (v.load) load_weights(v);
        cfg_shift = 4'(v.sh);
        cfg_relu  = v.relu;
        if (v.pre_clr) begin
            for (int b = 0; b < 7; b++) beat(9);
            clr      = 1'b1;
            in_valid = 1'b1;
            in_data  = 8'd9;
            tick();
            clr      = 1'b0;
            in_valid = 1'b0;
            chk("clr_busy", int'(busy), 0);
            chk("clr_in_ready", int'(in_ready), 1);
        end
        if (v.bp || v.rst_mid) out_ready = 1'b0;
        for (int b = 0; b < 16; b++) begin
            if (v.gaps && b > 0) begin
                repeat ($urandom_range(0, 2)) begin
                    tick();
                    chk("bubble_busy", int'(busy), 1);
                end
            end
            if (b == 15 && !v.rst_mid) begin
                for (int l = 0; l < 4; l++) begin
                    exp_t e;
                    e.lane = l;
                    e.data = v.res[l];
                    exp_q.push_back(e);
                end
            end
            beat(v.din);
        end
        // Now in the cycle after the last beat: ACT, then lane 0 the cycle after.
        chk("act_out_valid", int'(out_valid), 0);
        chk("act_in_ready", int'(in_ready), 0);
        tick();
        chk("lat_out_valid", int'(out_valid), 1);
        chk("lat_out_lane", int'(out_lane), 0);
        if (v.bp) begin
            for (int c = 0; c < 5; c++) begin
                tick();
                chk("bp_valid", int'(out_valid), 1);
                chk("bp_lane", int'(out_lane), 0);
                chk("bp_data", int'($signed(out_data)), v.res[0]);
                chk("bp_in_ready", int'(in_ready), 0);
            end
            out_ready = 1'b1;
        end
        if (v.rst_mid) begin
            tick();
            rst_n = 1'b0;
            #1;
            chk("rst_out_valid", int'(out_valid), 0);
            chk("rst_out_data", int'(out_data), 0);
            chk("rst_out_lane", int'(out_lane), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_in_ready", int'(in_ready), 1);
            tick();
            rst_n     = 1'b1;
            out_ready = 1'b1;
        end
        k = 0;
        while ((busy || exp_q.size() != 0) && k < 100) begin
            if (!v.gaps || exp_q.size() != 0) begin
                // busy must stay high until the final lane handshake
                chk("drain_busy", int'(busy), 1);
            end
            tick();
            k++;
        end
        chk("drain_timeout", (k >= 100) ? 1 : 0, 0);
        chk("idle_out_valid", int'(out_valid), 0);
    endtask

    initial begin
        //      w0   w1   w2    w3  din  sh  relu ld gap bp clr rst  results
        add_vec(1,   2,   -1,   0,  3,   2,  0,   1, 0,  0, 0,  0,   12,  24,  -12,  0);
        add_vec(1,   2,   -1,   0,  3,   2,  1,   0, 0,  0, 0,  0,   12,  24,  0,    0);
        add_vec(127, 127, -128, 0,  127, 0,  0,   1, 0,  1, 0,  0,   127, 127, -128, 0);
        add_vec(127, 127, -128, 0,  127, 15, 0,   0, 0,  0, 0,  0,   7,   7,   -8,   0);
        add_vec(-3,  5,   7,    -1, -2,  1,  1,   1, 1,  0, 0,  0,   48,  0,   0,    16);
        add_vec(-3,  5,   7,    -1, -2,  1,  0,   0, 0,  0, 1,  0,   48,  -80, -112, 16);
        add_vec(1,   2,   -1,   0,  3,   2,  0,   1, 0,  0, 0,  1,   0,   0,   0,    0);
        add_vec(0,   0,   0,    0,  5,   0,  0,   0, 0,  0, 0,  0,   0,   0,   0,    0);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_out_data", int'(out_data), 0);
        chk("reset_out_lane", int'(out_lane), 0);
        chk("reset_busy", int'(busy), 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i]);
            tick();
        end

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
